apb_master: RTL and testbench

APB initiator that converts a single-outstanding valid/ready request from a core-side requester into compliant APB3 SETUP/ACCESS transfers, and returns read data and error status on a one-cycle response strobe. It drives the APB slaves in the design, such as the UART register block, with registered outputs, and handles slave wait states via `pready_i`.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 145 ++++++++++++++
 tb/tb_apb_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB initiator.
package apb_pkg;

    // Transfer phases of the APB initiator.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;

endpackage : apb_pkg

// File: rtl/apb_master.sv
// APB3 initiator: turns one valid/ready request at a time into a SETUP/ACCESS
// transfer and returns read data and error status on a one-cycle strobe.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that
// wait longer than TIMEOUT_CYCLES cycles (response then reports an error).
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    // Core-side request
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    // Core-side response
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    // APB bus
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    apb_state_e state;
    apb_state_e next_state;
    logic       done;       // ACCESS completes with the slave ready
    logic       timeout;    // ACCESS abandoned after too many wait states

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_limit;

    // The limit is hit when the wait state in progress would bring the count to TIMEOUT_CYCLES.
    assign wait_limit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Only one transfer in flight: accept a new request only when idle.
    assign req_ready_o = (state == IDLE);

    // State register.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
        if (prst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and completion/timeout qualifiers.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        next_state = state;
        done       = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid_i) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_limit) begin
                    next_state = IDLE;
                    timeout    = 1'b1;
                end
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // APB outputs: control from the upcoming state, address/data captured on handshake.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
        end else begin
            psel_o    <= (next_state != IDLE);
            penable_o <= (next_state == ACCESS);
            if (req_valid_i && req_ready_o) begin
                pwrite_o <= req_write_i;
                paddr_o  <= req_addr_i;
                pwdata_o <= req_wdata_i;
            end
        end
    end

    // Response strobe plus read data / error that hold until the next completion.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= done | timeout;
            if (done) begin
                rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                rsp_err_o   <= pslverr_i;
            end else if (timeout) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b1;
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Wait-state counter: cleared on entry to SETUP, counts ACCESS cycles without pready.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            wait_cnt <= '0;
        end else if (next_state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table-driven single transfers plus
// hand-written back-to-back, reset-abort and timeout/no-timeout sequences.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          pclk_i = 1'b0;
    logic          prst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i = '0;
    logic          pready_i = 1'b0;
    logic          pslverr_i = 1'b0;

    int checks   = 0;
    int failures = 0;

    apb_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk_i      (pclk_i),
        .prst_i      (prst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    always #5 pclk_i = ~pclk_i;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge pclk_i);
        #1;
    endtask

    // One complete transfer; must be entered just after a rising edge while idle.
    task automatic run_txn(input vec_t v, input string tag);
        req_valid_i = 1'b1;
        req_write_i = v.write;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        pready_i    = 1'b0;
        prdata_i    = 32'hBAD0_BAD0;
        pslverr_i   = 1'b1;
        @(negedge pclk_i);
        check({tag, ".idle_ready"}, 64'(req_ready_o), 64'(1));
        check({tag, ".idle_psel"}, 64'(psel_o), 64'(0));
        next_cycle();
        // Scramble request fields to prove the APB side uses captured values.
        req_valid_i = 1'b0;
        req_write_i = ~v.write;
        req_addr_i  = ~v.addr;
        req_wdata_i = ~v.wdata;
        @(negedge pclk_i);
        check({tag, ".setup_psel"}, 64'(psel_o), 64'(1));
        check({tag, ".setup_penable"}, 64'(penable_o), 64'(0));
        check({tag, ".setup_ready"}, 64'(req_ready_o), 64'(0));
        check({tag, ".setup_paddr"}, 64'(paddr_o), 64'(v.addr));
        check({tag, ".setup_pwrite"}, 64'(pwrite_o), 64'(v.write));
        check({tag, ".setup_pwdata"}, 64'(pwdata_o), 64'(v.wdata));
        next_cycle();
        for (int i = 0; i <= v.waits; i++) begin
            pready_i  = (i == v.waits);
            prdata_i  = pready_i ? v.prdata : ~v.prdata;
            pslverr_i = pready_i ? v.slverr : ~v.slverr;
            @(negedge pclk_i);
            check($sformatf("%s.access%0d_psel", tag, i), 64'(psel_o), 64'(1));
            check($sformatf("%s.access%0d_penable", tag, i), 64'(penable_o), 64'(1));
            check($sformatf("%s.access%0d_paddr", tag, i), 64'(paddr_o), 64'(v.addr));
            check($sformatf("%s.access%0d_rsp_valid", tag, i), 64'(rsp_valid_o), 64'(0));
            next_cycle();
        end
        pready_i  = 1'b0;
        prdata_i  = ~v.prdata;
        pslverr_i = ~v.slverr;
        @(negedge pclk_i);
        check({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'(1));
        check({tag, ".rsp_rdata"}, 64'(rsp_rdata_o), 64'(v.exp_rdata));
        check({tag, ".rsp_err"}, 64'(rsp_err_o), 64'(v.exp_err));
        check({tag, ".rsp_psel"}, 64'(psel_o), 64'(0));
        check({tag, ".rsp_ready"}, 64'(req_ready_o), 64'(1));
        next_cycle();
        @(negedge pclk_i);
        check({tag, ".pulse_end"}, 64'(rsp_valid_o), 64'(0));
        check({tag, ".hold_rdata"}, 64'(rsp_rdata_o), 64'(v.exp_rdata));
        check({tag, ".hold_err"}, 64'(rsp_err_o), 64'(v.exp_err));
        check({tag, ".hold_paddr"}, 64'(paddr_o), 64'(v.addr));
        next_cycle();
    endtask

    initial begin
        int  n_access;
        bit  seen;
        logic [DW-1:0] cap_rdata;
        logic          cap_err;

        //           write addr    wdata          waits prdata         slverr exp_rdata      exp_err
        vecs[0] = '{1'b1, 12'h00C, 32'hA5A5_0001, 0, 32'hCAFE_BABE, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 12'h010, 32'h1111_2222, 2, 32'h0000_00FF, 1'b0, 32'h0000_00FF, 1'b0};
        vecs[2] = '{1'b1, 12'h020, 32'h1234_5678, 1, 32'h7777_7777, 1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 12'hFFC, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b0, 12'h004, 32'hFFFF_FFFF, 3, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 1'b0};

        // Reset state.
        #12;
        check("rst.psel", 64'(psel_o), 64'(0));
        check("rst.penable", 64'(penable_o), 64'(0));
        check("rst.pwrite", 64'(pwrite_o), 64'(0));
        check("rst.paddr", 64'(paddr_o), 64'(0));
        check("rst.pwdata", 64'(pwdata_o), 64'(0));
        check("rst.rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst.rsp_err", 64'(rsp_err_o), 64'(0));
        check("rst.rsp_rdata", 64'(rsp_rdata_o), 64'(0));
        check("rst.req_ready", 64'(req_ready_o), 64'(1));
        #11 prst_i = 1'b0;
        next_cycle();

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: valid held across two requests; second handshake on the first response.
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 12'h0A0;
        pready_i    = 1'b1;
        prdata_i    = 32'h0000_00A0;
        pslverr_i   = 1'b0;
        next_cycle();
        req_addr_i = 12'h0B0;
        @(negedge pclk_i);
        check("b2b.a_setup_paddr", 64'(paddr_o), 64'(12'h0A0));
        check("b2b.a_setup_ready", 64'(req_ready_o), 64'(0));
        next_cycle();
        @(negedge pclk_i);
        check("b2b.a_access_penable", 64'(penable_o), 64'(1));
        check("b2b.a_access_paddr", 64'(paddr_o), 64'(12'h0A0));
        next_cycle();
        prdata_i = 32'h0000_00B0;
        @(negedge pclk_i);
        check("b2b.a_rsp_valid", 64'(rsp_valid_o), 64'(1));
        check("b2b.a_rsp_rdata", 64'(rsp_rdata_o), 64'(32'h0000_00A0));
        check("b2b.gap_psel", 64'(psel_o), 64'(0));
        check("b2b.gap_ready", 64'(req_ready_o), 64'(1));
        next_cycle();
        req_valid_i = 1'b0;
        @(negedge pclk_i);
        check("b2b.b_setup_psel", 64'(psel_o), 64'(1));
        check("b2b.b_setup_penable", 64'(penable_o), 64'(0));
        check("b2b.b_setup_paddr", 64'(paddr_o), 64'(12'h0B0));
        check("b2b.b_setup_rsp_valid", 64'(rsp_valid_o), 64'(0));
        next_cycle();
        @(negedge pclk_i);
        check("b2b.b_access_penable", 64'(penable_o), 64'(1));
        next_cycle();
        pready_i = 1'b0;
        @(negedge pclk_i);
        check("b2b.b_rsp_valid", 64'(rsp_valid_o), 64'(1));
        check("b2b.b_rsp_rdata", 64'(rsp_rdata_o), 64'(32'h0000_00B0));
        next_cycle();

        // Reset pulsed during ACCESS: bus drops at once, no response follows.
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 12'h0C0;
        req_wdata_i = 32'h0BAD_F00D;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        next_cycle();
        req_valid_i = 1'b0;
        next_cycle();
        check("rstmid.access_penable", 64'(penable_o), 64'(1));
        #2 prst_i = 1'b1;
        #1;
        check("rstmid.psel_async", 64'(psel_o), 64'(0));
        check("rstmid.penable_async", 64'(penable_o), 64'(0));
        pready_i = 1'b1;
        #9 prst_i = 1'b0;
        seen = 1'b0;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk_i);
            if (rsp_valid_o || psel_o) seen = 1'b1;
            next_cycle();
        end
        check("rstmid.no_response", 64'(seen), 64'(0));
        check("rstmid.ready_after", 64'(req_ready_o), 64'(1));
        pready_i = 1'b0;
        run_txn(vecs[1], "after_rst");

        // Slave never ready.
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 12'h100;
        pready_i    = 1'b0;
        prdata_i    = 32'hFFFF_0000;
        pslverr_i   = 1'b0;
        next_cycle();
        req_valid_i = 1'b0;
        n_access  = 0;
        seen      = 1'b0;
        cap_rdata = '1;
        cap_err   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge pclk_i);
            if (rsp_valid_o) begin
                seen      = 1'b1;
                cap_rdata = rsp_rdata_o;
                cap_err   = rsp_err_o;
            end else if (penable_o) begin
                n_access++;
            end
            next_cycle();
        end
        check("timeout.seen", 64'(seen), 64'(1));
        check("timeout.access_cycles", 64'(n_access), 64'(4));
        check("timeout.rsp_err", 64'(cap_err), 64'(1));
        check("timeout.rsp_rdata", 64'(cap_rdata), 64'(0));
        check("timeout.ready_after", 64'(req_ready_o), 64'(1));
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge pclk_i);
            if (rsp_valid_o) seen = 1'b1;
            next_cycle();
        end
        check("notimeout.no_response", 64'(seen), 64'(0));
        check("notimeout.still_psel", 64'(psel_o), 64'(1));
        check("notimeout.still_penable", 64'(penable_o), 64'(1));
        prst_i = 1'b1;
        #3 prst_i = 1'b0;
        next_cycle();
        check("notimeout.ready_after_rst", 64'(req_ready_o), 64'(1));
`endif
        run_txn(vecs[0], "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_apb_master
